elevator_call_scheduler: RTL and testbench

//   Call scheduler/sequencer for the 3-floor elevator car FSM. Latches hall-call requests,

---
 rtl/elevator_call_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_elevator_call_scheduler.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_call_scheduler.sv
// SCAN call scheduler for a 3-floor car: latches hall calls, issues one-floor motor steps, times travel and door dwell.
// Latency: call to door_open is 3 cycles at the current floor; no backpressure, the car FSM follows every update strobe.
module elevator_call_scheduler #(
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] call_req,
    input  logic [1:0] floor,
    input  logic [1:0] movement,
    output logic [1:0] motor_control,
    output logic       update,
    output logic [2:0] pending,
    output logic       door_open,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECIDE,
        S_STEP,
        S_TRAVEL,
        S_DOOR
    } state_t;

    localparam logic [1:0] MC_UP   = 2'b10;
    localparam logic [1:0] MC_DN   = 2'b01;
    localparam logic [1:0] MC_STOP = 2'b00;

    localparam int MAXC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] TRAVEL_LAST = CW'(TRAVEL_CYCLES - 2);
    localparam logic [CW-1:0] DOOR_LAST   = CW'(DOOR_CYCLES - 1);

    state_t        r_state;
    logic          r_dir;
    logic          r_to_door;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_pending;
    logic [1:0]    r_motor_control;
    logic          r_update;
    logic          r_door_open;
    logic          r_busy;

    state_t        w_state_nxt;
    logic          w_dir_nxt;
    logic          w_to_door_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [2:0]    w_pending_nxt;
    logic [1:0]    w_mc_nxt;
    logic [2:0]    w_call_mask;
    logic [2:0]    w_floor_oh;
    logic          w_above;
    logic          w_below;

    always_comb begin
        w_floor_oh = 3'b000;
        w_above    = 1'b0;
        w_below    = 1'b0;
        case (floor)
            2'b00: begin
                w_floor_oh = 3'b001;
                w_above    = |r_pending[2:1];
            end
            2'b01: begin
                w_floor_oh = 3'b010;
                w_above    = r_pending[2];
                w_below    = r_pending[0];
            end
            2'b10: begin
                w_floor_oh = 3'b100;
                w_below    = |r_pending[1:0];
            end
            default: begin
                w_floor_oh = 3'b000;
            end
        endcase
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_dir_nxt     = r_dir;
        w_to_door_nxt = r_to_door;
        w_cnt_nxt     = r_cnt;
        w_mc_nxt      = r_motor_control;
        w_call_mask   = 3'b111;
        case (r_state)
            S_IDLE: begin
                if (|r_pending) w_state_nxt = S_DECIDE;
            end
            S_DECIDE: begin
                // An invalid floor code parks the scheduler here until the car reports a real floor.
                if (floor == 2'b11) begin
                    w_state_nxt = S_DECIDE;
                end else if (|(r_pending & w_floor_oh)) begin
                    if (movement != 2'b00) begin
                        w_mc_nxt      = MC_STOP;
                        w_to_door_nxt = 1'b1;
                        w_state_nxt   = S_STEP;
                    end else begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_DOOR;
                    end
                end else if (w_above && (r_dir || !w_below)) begin
                    w_mc_nxt    = MC_UP;
                    w_dir_nxt   = 1'b1;
                    w_state_nxt = S_STEP;
                end else if (w_below) begin
                    w_mc_nxt    = MC_DN;
                    w_dir_nxt   = 1'b0;
                    w_state_nxt = S_STEP;
                end else if (movement != 2'b00) begin
                    w_mc_nxt      = MC_STOP;
                    w_to_door_nxt = 1'b0;
                    w_state_nxt   = S_STEP;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_STEP: begin
                w_cnt_nxt = '0;
                if (r_motor_control != MC_STOP) begin
                    w_state_nxt = S_TRAVEL;
                end else if (r_to_door) begin
                    w_state_nxt = S_DOOR;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_TRAVEL: begin
                if (r_cnt == TRAVEL_LAST) begin
                    w_state_nxt = S_DECIDE;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_DOOR: begin
                // A press at the open floor extends the dwell instead of queuing a new call.
                w_call_mask = ~w_floor_oh;
                if (|(call_req & w_floor_oh)) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == DOOR_LAST) begin
                    w_state_nxt = S_DECIDE;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_pending_nxt = r_pending | (call_req & w_call_mask);
        if ((w_state_nxt == S_DOOR) && (r_state != S_DOOR)) begin
            w_pending_nxt = w_pending_nxt & ~w_floor_oh;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_dir           <= 1'b1;
            r_to_door       <= 1'b0;
            r_cnt           <= '0;
            r_pending       <= 3'b000;
            r_motor_control <= MC_STOP;
            r_update        <= 1'b0;
            r_door_open     <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_dir           <= w_dir_nxt;
            r_to_door       <= w_to_door_nxt;
            r_cnt           <= w_cnt_nxt;
            r_pending       <= w_pending_nxt;
            r_motor_control <= w_mc_nxt;
            r_update        <= (w_state_nxt == S_STEP);
            r_door_open     <= (w_state_nxt == S_DOOR);
            r_busy          <= (w_state_nxt != S_IDLE);
        end
    end

    assign motor_control = r_motor_control;
    assign update        = r_update;
    assign pending       = r_pending;
    assign door_open     = r_door_open;
    assign busy          = r_busy;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Bench for elevator_call_scheduler with a behavioural 3-floor car as its load.
module tb_elevator_call_scheduler;

    logic       clk;
    logic       reset;
    logic [2:0] call_req;
    logic [1:0] car_floor;
    logic [1:0] car_mov;
    logic [1:0] motor_control;
    logic       update;
    logic [2:0] pending;
    logic       door_open;
    logic       busy;

    logic       car_ld;
    logic [1:0] car_ld_floor;
    logic [1:0] car_ld_mov;

    int total;
    int bad;

    elevator_call_scheduler #(
        .TRAVEL_CYCLES(4),
        .DOOR_CYCLES  (6)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .call_req     (call_req),
        .floor        (car_floor),
        .movement     (car_mov),
        .motor_control(motor_control),
        .update       (update),
        .pending      (pending),
        .door_open    (door_open),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Car model: acts on the strobe, can be preloaded to a floor/movement.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            car_floor <= 2'b00;
            car_mov   <= 2'b00;
        end else if (car_ld) begin
            car_floor <= car_ld_floor;
            car_mov   <= car_ld_mov;
        end else if (update) begin
            case (motor_control)
                2'b10: begin
                    if (car_floor != 2'b10) car_floor <= car_floor + 2'd1;
                    car_mov <= 2'b10;
                end
                2'b01: begin
                    if (car_floor != 2'b00) car_floor <= car_floor - 2'd1;
                    car_mov <= 2'b01;
                end
                default: car_mov <= 2'b00;
            endcase
        end
    end

    typedef struct {
        string       name;
        logic [1:0]  start_floor;
        logic [1:0]  start_mov;
        logic [2:0]  call;
        int          n_strobes;
        logic [15:0] mc_seq;
        int          door_cycles;
        logic [1:0]  end_floor;
    } vec_t;

    vec_t vecs[6];

    function automatic vec_t mk(string nm, logic [1:0] sf, logic [1:0] sm, logic [2:0] c,
                                int ns, logic [15:0] seq, int dc, logic [1:0] ef);
        vec_t v;
        v.name        = nm;
        v.start_floor = sf;
        v.start_mov   = sm;
        v.call        = c;
        v.n_strobes   = ns;
        v.mc_seq      = seq;
        v.door_cycles = dc;
        v.end_floor   = ef;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic run_vec(input vec_t v);
        logic [1:0] got_mc[8];
        int n;
        int gap;
        int door;
        bit seen_busy;
        bit done;
        do_reset();
        car_ld       = 1'b1;
        car_ld_floor = v.start_floor;
        car_ld_mov   = v.start_mov;
        tick();
        car_ld   = 1'b0;
        call_req = v.call;
        tick();
        call_req  = 3'b000;
        n         = 0;
        gap       = 100;
        door      = 0;
        seen_busy = 1'b0;
        done      = 1'b0;
        for (int k = 0; k < 8; k++) got_mc[k] = 2'b11;
        for (int c = 0; c < 400; c++) begin
            tick();
            if (update) begin
                if (n < 8) got_mc[n] = motor_control;
                n++;
                check({v.name, " strobe gap"}, 32'(gap >= 3), 32'd1);
                gap = 0;
            end else begin
                gap++;
            end
            if (door_open) door++;
            if (busy) seen_busy = 1'b1;
            if (seen_busy && !busy) begin
                done = 1'b1;
                break;
            end
        end
        check({v.name, " finished"}, 32'(done), 32'd1);
        check({v.name, " strobe count"}, 32'(n), 32'(v.n_strobes));
        for (int k = 0; k < v.n_strobes && k < 8; k++) begin
            check({v.name, " strobe mc"}, 32'(got_mc[k]), 32'(v.mc_seq[2*k +: 2]));
        end
        check({v.name, " door cycles"}, 32'(door), 32'(v.door_cycles));
        check({v.name, " end floor"}, 32'(car_floor), 32'(v.end_floor));
        check({v.name, " pending cleared"}, 32'(pending), 32'd0);
    endtask

    initial begin
        int dc;
        int n;
        bit seen;
        total        = 0;
        bad          = 0;
        reset        = 1'b0;
        call_req     = 3'b000;
        car_ld       = 1'b0;
        car_ld_floor = 2'b00;
        car_ld_mov   = 2'b00;

        // name, start floor, start movement, calls, strobes, mc per strobe (2 bits each, first in LSBs), door cycles, end floor
        vecs[0] = mk("up2",      2'd0, 2'b00, 3'b100, 3, 16'h000A,  6, 2'd2);
        vecs[1] = mk("here",     2'd0, 2'b00, 3'b001, 0, 16'h0000,  6, 2'd0);
        vecs[2] = mk("scan",     2'd1, 2'b10, 3'b101, 5, 16'h0052, 12, 2'd0);
        vecs[3] = mk("down1",    2'd2, 2'b00, 3'b010, 2, 16'h0001,  6, 2'd1);
        vecs[4] = mk("all",      2'd1, 2'b00, 3'b111, 5, 16'h0052, 18, 2'd0);
        vecs[5] = mk("stophere", 2'd0, 2'b10, 3'b001, 1, 16'h0000,  6, 2'd0);

        // Reset values
        reset = 1'b1;
        #3;
        check("rst mc", 32'(motor_control), 32'd0);
        check("rst update", 32'(update), 32'd0);
        check("rst pending", 32'(pending), 32'd0);
        check("rst door", 32'(door_open), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        do_reset();

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Latency: call at the current floor opens the door three cycles later, no strobe
        do_reset();
        call_req = 3'b001;
        tick();
        call_req = 3'b000;
        check("lat pending t+1", 32'(pending), 32'd1);
        check("lat door t+1", 32'(door_open), 32'd0);
        tick();
        check("lat busy t+2", 32'(busy), 32'd1);
        check("lat door t+2", 32'(door_open), 32'd0);
        tick();
        check("lat door t+3", 32'(door_open), 32'd1);
        check("lat pending t+3", 32'(pending), 32'd0);
        dc   = 1;
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (update) seen = 1'b1;
            if (!door_open) break;
            dc++;
        end
        check("lat door cycles", 32'(dc), 32'd6);
        check("lat no strobe", 32'(seen), 32'd0);

        // Dwell restart by a press on the open floor at dwell cycle 4
        do_reset();
        car_ld       = 1'b1;
        car_ld_floor = 2'd1;
        car_ld_mov   = 2'b00;
        tick();
        car_ld   = 1'b0;
        call_req = 3'b010;
        tick();
        call_req = 3'b000;
        tick();
        tick();
        check("dwell open", 32'(door_open), 32'd1);
        dc = 1;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (door_open) dc++;
        end
        call_req = 3'b010;
        tick();
        call_req = 3'b000;
        check("dwell pending1", 32'(pending), 32'd0);
        if (door_open) dc++;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (!door_open) break;
            dc++;
        end
        check("dwell restart cycles", 32'(dc), 32'd10);
        check("dwell pending end", 32'(pending), 32'd0);

        // Reset during TRAVEL
        do_reset();
        call_req = 3'b100;
        tick();
        call_req = 3'b000;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (update) begin
                seen = 1'b1;
                break;
            end
        end
        check("mid first strobe", 32'(seen), 32'd1);
        tick();
        tick();
        check("mid pre mc", 32'(motor_control), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        check("mid rst update", 32'(update), 32'd0);
        check("mid rst mc", 32'(motor_control), 32'd0);
        check("mid rst pending", 32'(pending), 32'd0);
        check("mid rst busy", 32'(busy), 32'd0);
        tick();
        reset = 1'b0;
        n = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (update) n++;
        end
        check("mid no strobes", 32'(n), 32'd0);
        check("mid car floor", 32'(car_floor), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
